// File: rtl/en_pulse_gen_if.sv
// en_pulse_gen_if: request/status bundle between a controller and en_pulse_gen.
// The abort signal exists only when EN_PULSE_GEN_ABORT_EN is defined.
`default_nettype none

interface en_pulse_gen_if #(
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
);
  logic             start;
  logic [CNT_W-1:0] count;
  logic [GAP_W-1:0] gap;
`ifdef EN_PULSE_GEN_ABORT_EN
  logic             abort;
`endif
  logic             en;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] remaining;

`ifdef EN_PULSE_GEN_ABORT_EN
  modport master (output start, count, gap, abort, input en, busy, done, remaining);
  modport slave  (input start, count, gap, abort, output en, busy, done, remaining);
`else
  modport master (output start, count, gap, input en, busy, done, remaining);
  modport slave  (input start, count, gap, output en, busy, done, remaining);
`endif
endinterface

`default_nettype wire

// File: rtl/en_pulse_gen.sv
// +--------------------------------------------------------------------------+
// | en_pulse_gen: Moore strobe generator emitting count en pulses spaced by  |
// | gap idle cycles, then a one-cycle done. Option: EN_PULSE_GEN_ABORT_EN.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module en_pulse_gen #(
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  en_pulse_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] rem_q;
  logic [CNT_W-1:0] rem_nx;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_q_nx;
  logic [GAP_W-1:0] gcnt;
  logic [GAP_W-1:0] gcnt_nx;
  logic             abort_hit;
  logic             en_q;
  logic             busy_q;
  logic             done_q;

`ifdef EN_PULSE_GEN_ABORT_EN
  assign abort_hit = bus.abort;
`else
  assign abort_hit = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    rem_nx   = rem_q;
    gap_q_nx = gap_q;
    gcnt_nx  = gcnt;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.count != '0) begin
            rem_nx   = bus.count;
            gap_q_nx = bus.gap;
            state_nx = PULSE;
          end else begin
            rem_nx   = '0;
            state_nx = DONE;
          end
        end
      end
      PULSE: begin
        // The pulse in flight this cycle is counted even if it is aborted.
        rem_nx = rem_q - CNT_W'(1);
        if (rem_nx == '0 || abort_hit) begin
          state_nx = DONE;
        end else if (gap_q == '0) begin
          state_nx = PULSE;
        end else begin
          state_nx = GAP;
          gcnt_nx  = gap_q;
        end
      end
      GAP: begin
        gcnt_nx = gcnt - GAP_W'(1);
        if (abort_hit) begin
          state_nx = DONE;
          gcnt_nx  = '0;
        end else if (gcnt == GAP_W'(1)) begin
          state_nx = PULSE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they align with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rem_q  <= '0;
      gap_q  <= '0;
      gcnt   <= '0;
      en_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      rem_q  <= rem_nx;
      gap_q  <= gap_q_nx;
      gcnt   <= gcnt_nx;
      en_q   <= (state_nx == PULSE);
      busy_q <= (state_nx == PULSE) || (state_nx == GAP);
      done_q <= (state_nx == DONE);
    end
  end

  assign bus.en        = en_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.remaining = rem_q;

endmodule

`default_nettype wire

// File: tb/tb_en_pulse_gen.sv
// tb_en_pulse_gen: directed and randomized checks of en_pulse_gen against a
// sequence-level reference model. Honours EN_PULSE_GEN_ABORT_EN.
`default_nettype none

module tb_en_pulse_gen;
  localparam int CNT_W = 4;
  localparam int GAP_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  en_pulse_gen_if #(.CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();

  en_pulse_gen #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic             en;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] rem;
  } exp_t;

  int   n_chk  = 0;
  int   n_pass = 0;
  bit   check_en = 1'b0;
  exp_t cur;
  exp_t q[$];
  logic [CNT_W-1:0] last_rem;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  // Reference model: on acceptance, the whole output trace of the sequence is queued.
  always @(posedge clk or negedge rst_n) begin : model
    bit idle;
    bit aborted;
    int n;
    int g;
    exp_t e;
    logic [CNT_W-1:0] r;
    if (!rst_n) begin
      q.delete();
      cur      = '0;
      last_rem = '0;
    end else begin
      idle    = !cur.busy && !cur.done;
      aborted = 1'b0;
`ifdef EN_PULSE_GEN_ABORT_EN
      if (cur.busy && bus.abort) begin
        q.delete();
        r        = cur.en ? cur.rem - CNT_W'(1) : cur.rem;
        cur      = '{en: 1'b0, busy: 1'b0, done: 1'b1, rem: r};
        last_rem = r;
        aborted  = 1'b1;
      end
`endif
      if (!aborted) begin
        if (idle && bus.start) begin
          n = int'(bus.count);
          g = int'(bus.gap);
          for (int i = 0; i < n; i++) begin
            e = '{en: 1'b1, busy: 1'b1, done: 1'b0, rem: CNT_W'(n - i)};
            q.push_back(e);
            if (i < n - 1) begin
              for (int k = 0; k < g; k++) begin
                e = '{en: 1'b0, busy: 1'b1, done: 1'b0, rem: CNT_W'(n - i - 1)};
                q.push_back(e);
              end
            end
          end
          e = '{en: 1'b0, busy: 1'b0, done: 1'b1, rem: '0};
          q.push_back(e);
          last_rem = '0;
        end
        if (q.size() > 0) cur = q.pop_front();
        else cur = '{en: 1'b0, busy: 1'b0, done: 1'b0, rem: last_rem};
      end
    end
  end

  always @(negedge clk) begin
    if (check_en)
      check("cycle", {25'd0, bus.en, bus.busy, bus.done, bus.remaining}, {25'd0, cur});
  end

  task automatic start_seq(input int c, input int g);
    @(negedge clk);
    bus.start = 1'b1;
    bus.count = CNT_W'(c);
    bus.gap   = GAP_W'(g);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic cap(input int n, input int inj_at, input int ic, input int ig,
                     output logic [31:0] ev, output logic [31:0] bv,
                     output logic [31:0] dv, output logic [127:0] rv);
    ev = '0; bv = '0; dv = '0; rv = '0;
    for (int i = 0; i < n; i++) begin
      ev[i] = bus.en;
      bv[i] = bus.busy;
      dv[i] = bus.done;
      rv[4*i +: 4] = bus.remaining;
      if (i == inj_at) begin
        bus.start = 1'b1;
        bus.count = CNT_W'(ic);
        bus.gap   = GAP_W'(ig);
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  initial begin
    logic [31:0]  ev, bv, dv;
    logic [127:0] rv;
    int seq, pulses, zg;

    bus.start = 1'b0;
    bus.count = '0;
    bus.gap   = '0;
`ifdef EN_PULSE_GEN_ABORT_EN
    bus.abort = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {28'd0, bus.en, bus.busy, bus.done, 1'b0} | {28'd0, bus.remaining}, 32'd0);
    rst_n = 1'b1;
    check_en = 1'b1;
    repeat (2) @(negedge clk);

    start_seq(3, 0);
    cap(5, -1, 0, 0, ev, bv, dv, rv);
    check("c3g0_en",   ev, 32'b00111);
    check("c3g0_busy", bv, 32'b00111);
    check("c3g0_done", dv, 32'b01000);
    check("c3g0_rem",  rv[31:0], 32'h0000_0123);

    start_seq(2, 2);
    cap(6, -1, 0, 0, ev, bv, dv, rv);
    check("c2g2_en",   ev, 32'b001001);
    check("c2g2_busy", bv, 32'b001111);
    check("c2g2_done", dv, 32'b010000);
    check("c2g2_rem",  rv[31:0], 32'h0000_1112);

    start_seq(0, 5);
    cap(3, -1, 0, 0, ev, bv, dv, rv);
    check("c0_en",   ev, 32'b000);
    check("c0_busy", bv, 32'b000);
    check("c0_done", dv, 32'b001);

    start_seq(3, 1);
    cap(8, 1, 7, 0, ev, bv, dv, rv);
    check("restart_ignored_en",   ev, 32'b00010101);
    check("restart_ignored_done", dv, 32'b00100000);

    // Behavioural mod-4 sequencer: z is high while its state is 3.
    start_seq(4, 1);
    seq = 0; pulses = 0; zg = 0;
    for (int i = 0; i < 10; i++) begin
      if (seq == 3 && !bus.en) zg++;
      if (bus.en) begin
        pulses++;
        seq = (seq + 1) % 4;
      end
      @(negedge clk);
    end
    check("seq_pulses", pulses, 4);
    check("seq_state",  seq, 0);
    check("seq_z_gap",  zg, 1);

    start_seq(5, 2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {28'd0, bus.en, bus.busy, bus.done, 1'b0} | {28'd0, bus.remaining}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_idle", {28'd0, bus.en, bus.busy, bus.done, 1'b0} | {28'd0, bus.remaining}, 32'd0);

`ifdef EN_PULSE_GEN_ABORT_EN
    start_seq(5, 1);
    for (int i = 0; i < 7; i++) begin
      ev[i] = bus.en;
      dv[i] = bus.done;
      rv[4*i +: 4] = bus.remaining;
      bus.abort = (i == 3);
      @(negedge clk);
    end
    bus.abort = 1'b0;
    check("abort_done", dv[6:0], 32'b0010000);
    check("abort_en",   ev[6:0], 32'b0000101);
    check("abort_rem",  rv[19:16], 32'd3);
`endif

    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      bus.start = ($urandom_range(0, 3) == 0);
      bus.count = ($urandom_range(0, 7) == 0) ? CNT_W'(15) : CNT_W'($urandom_range(0, 6));
      bus.gap   = ($urandom_range(0, 7) == 0) ? GAP_W'($urandom_range(0, 15)) : GAP_W'($urandom_range(0, 2));
`ifdef EN_PULSE_GEN_ABORT_EN
      bus.abort = ($urandom_range(0, 39) == 0);
`endif
    end
    @(negedge clk);
    bus.start = 1'b0;
`ifdef EN_PULSE_GEN_ABORT_EN
    bus.abort = 1'b0;
`endif
    repeat (300) @(negedge clk);
    check("final_idle", {29'd0, bus.en, bus.busy, bus.done}, 32'd0);

    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/en_pulse_gen.md
# en_pulse_gen

Moore-style strobe generator that drives the single-bit `en` advance input of the team's mod-4 state-sequencer. On a `start` request it emits a programmed number of one-cycle `en` pulses, separated by a programmed number of idle cycles. It then reports completion with a one-cycle `done`. It sits upstream of the sequencer as the producer of its `en` stream.

## Interface
- `CNT_W`, default 4: width of the pulse-count request and of `remaining`.
- `GAP_W`, default 4: width of the inter-pulse gap request.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  request; sampled only in IDLE.
- `count`  in  CNT_W  number of `en` pulses to emit; sampled with `start`.
- `gap`  in  GAP_W  low cycles between consecutive pulses; sampled with `start`.
- `abort`  in  1  present only with `EN_PULSE_GEN_ABORT_EN`; cancels the sequence.
- `en`  out  1  strobe to the downstream sequencer.
- `busy`  out  1  high while a sequence is in progress.
- `done`  out  1  one-cycle completion flag.
- `remaining`  out  CNT_W  pulses still to be emitted.

## Operation
- The state register encodes IDLE, PULSE, GAP and DONE.
- All outputs are decoded from the registered state and counters only (Moore); no input reaches an output combinationally.
  - `en` = (state==PULSE).
  - `busy` = (state==PULSE or GAP).
  - `done` = (state==DONE).
- IDLE:
  - `start`=1 with `count`!=0: latch `count` into `remaining` and `gap` into `gap_q`, then go to PULSE.
  - `start`=1 with `count`==0: go to DONE; no `en` is emitted and `remaining` stays 0.
- PULSE: `remaining` decrements by 1 at the exiting edge. Next state:
  - DONE if the decremented value is 0.
  - Otherwise PULSE again if `gap_q`==0 (back-to-back pulses, `en` stays high).
  - Otherwise GAP, with the gap counter loaded with `gap_q`.
- GAP: the gap counter decrements each cycle; on the cycle the counter equals 1, the next state is PULSE. This yields exactly `gap_q` low cycles between pulses.
- DONE: unconditionally returns to IDLE on the next edge.
- `start` in PULSE, GAP or DONE is ignored and is not queued.
- `count` and `gap` are don't-care except in the cycle `start` is accepted. Changes during a sequence have no effect.
- Full-scale `count` (2^CNT_W−1) and full-scale `gap` are legal; no counter wraps.
- `remaining` holds 0 in IDLE after a normal completion.
- An undefined state encoding recovers to IDLE on the next edge.

## Timing
- Reset: state=IDLE, `en`=0, `busy`=0, `done`=0, `remaining`=0, gap counter=0, `gap_q`=0. Reset takes effect immediately, even mid-sequence, without waiting for `clk`.
- Start latency: `start` sampled at edge k puts `en` high in the cycle after edge k. `en` is a full-cycle, glitch-free registered output.
- Sequence length: `count`=N, `gap`=G, N≥1 occupies N + (N−1)·G cycles of PULSE/GAP, followed by 1 cycle of DONE, then IDLE.
- `count`=0: `done` is high in the cycle after edge k.
- Earliest restart: a new `start` can be accepted 2 cycles after the last `en` (the IDLE cycle after DONE).

## Configuration
- `EN_PULSE_GEN_ABORT_EN` defined:
  - The `abort` port exists.
  - `abort`=1 sampled in PULSE or GAP forces DONE on the next edge.
  - `en` is not asserted again, and `remaining` freezes at its value at that edge (pulses not sent).
  - `abort` in IDLE or DONE is ignored.
  - If `abort` and the final-pulse exit coincide, the result is DONE with `remaining`=0.
- Not defined: no `abort` port and no abort logic; every accepted sequence runs to completion.

## Test plan
- `count`=3, `gap`=0: `en` high for 3 consecutive cycles starting the cycle after `start`; `remaining` goes 3→2→1→0; `done` is high for 1 cycle, then IDLE.
- `count`=2, `gap`=2: `en` pattern 1,0,0,1; `busy` high for 4 cycles; `done` high in cycle 5.
- `count`=0 with `start`: `done` high in the next cycle, `en` never high, `busy` never high.
- `start` pulsed again mid-sequence with different `count`/`gap`: ignored; the original pattern completes unchanged.
- `count`=4, `gap`=1 feeding the mod-4 sequencer: exactly 4 `en` pulses; the sequencer returns to its initial state; its `z` output is high only between the third and fourth pulse.
- `rst_n` asserted low during GAP of `count`=5: `en`/`busy`/`done`/`remaining` go to 0 immediately and stay in IDLE after release. With `EN_PULSE_GEN_ABORT_EN` defined, `abort` in the second GAP of `count`=5 gives `done` on the next cycle with `remaining`=3.
